// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed N-tap FIR: circular sample buffer and coefficient bank driven through one shared MAC.
// Optional output clamping with a sat pulse is compiled in by defining FIR_SAT_EN.
module fir_mac_sequencer #(
  parameter int N = 64,
  parameter int DW = 24,
  parameter int CW = 24,
  localparam int ADDR_W = $clog2(N),
  parameter int ACC_W = DW + CW + ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DW-1:0]     s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DW-1:0]     m_data,
  input  logic              coef_we,
  input  logic [ADDR_W-1:0] coef_addr,
  input  logic [CW-1:0]     coef_wdata,
  output logic              busy,
  output logic              sat
);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t state, state_next;

  logic signed [DW-1:0]    sbuf [N];
  logic signed [CW-1:0]    coef [N];
  logic [ADDR_W-1:0]       wr_ptr;
  logic [ADDR_W-1:0]       base;
  logic [ADDR_W-1:0]       k;
  logic [ADDR_W-1:0]       rd_addr;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [DW+CW-1:0] prod;
  logic signed [DW-1:0]    s_rd;
  logic signed [CW-1:0]    c_rd;
  logic [DW-1:0]           out_dat;
  logic                    accept;
  logic                    last_mac;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    s_ready    = 1'b0;
    m_valid    = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    last_mac   = 1'b0;
    case (state)
      IDLE: begin
        s_ready = !reset;
        accept  = s_valid && !reset;
        if (accept) state_next = MAC;
      end
      MAC: begin
        busy     = 1'b1;
        last_mac = (k == ADDR_W'(N - 1));
        if (last_mac) state_next = OUT;
      end
      OUT: begin
        busy    = 1'b1;
        m_valid = 1'b1;
        if (m_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Newest sample sits at base; tap k reaches back k samples around the ring.
  assign rd_addr  = base - k;
  assign s_rd     = sbuf[rd_addr];
  assign c_rd     = coef[k];
  assign prod     = (DW+CW)'(s_rd) * (DW+CW)'(c_rd);
  assign prod_ext = ACC_W'(prod);
  assign acc_next = acc + prod_ext;

`ifdef FIR_SAT_EN
  logic ovf;
  logic sat_q;

  // Bits above the output slice must all match the sign for the slice to be exact.
  assign ovf = !((&acc_next[ACC_W-1:DW+CW-1]) || !(|acc_next[ACC_W-1:DW+CW-1]));

  always_comb begin
    out_dat = acc_next[DW+CW-1:CW];
    if (ovf) out_dat = acc_next[ACC_W-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
  end

  always_ff @(posedge clk) begin
    if (reset)         sat_q <= 1'b0;
    else if (last_mac) sat_q <= ovf;
    else               sat_q <= 1'b0;
  end

  assign sat = sat_q;
`else
  assign out_dat = acc_next[DW+CW-1:CW];
  assign sat     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        sbuf[i] <= '0;
        coef[i] <= '0;
      end
      wr_ptr <= '0;
      base   <= '0;
      k      <= '0;
      acc    <= '0;
      m_data <= '0;
    end else begin
      if (state == IDLE && coef_we) coef[coef_addr] <= coef_wdata;
      if (accept) begin
        sbuf[wr_ptr] <= s_data;
        base         <= wr_ptr;
        wr_ptr       <= wr_ptr + 1'b1;
        acc          <= '0;
        k            <= '0;
      end
      if (state == MAC) begin
        acc <= acc_next;
        k   <= k + 1'b1;
        if (last_mac) m_data <= out_dat;
      end
    end
  end

endmodule
